// File: rtl/ecc_apb_sequencer.sv
// ecc_apb_sequencer: accepts one ECC command and programs the ECC core over
// APB as four write beats (DATA_IN, CODEWORD_WIDTH, NOISE, CTRL). It then
// waits for operation_done and returns the core result on a valid/ready
// response channel.
// Optional feature: define ECC_SEQ_WATCHDOG_EN to enable a WAIT_DONE watchdog
// that reports a timeout response after TIMEOUT_CYCLES cycles.
module ecc_apb_sequencer #(
    parameter int unsigned AMBA_WORD       = 32,
    parameter int unsigned AMBA_ADDR_WIDTH = 20,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned TIMEOUT_CYCLES  = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    // command channel
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [1:0]                 req_op,
    input  logic [DATA_WIDTH-1:0]      req_data,
    input  logic [1:0]                 req_width,
    input  logic [DATA_WIDTH-1:0]      req_noise,
    // APB master
    output logic                       PSEL,
    output logic                       PENABLE,
    output logic                       PWRITE,
    output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    output logic [AMBA_WORD-1:0]       PWDATA,
    // ECC core status
    input  logic                       operation_done,
    input  logic [DATA_WIDTH-1:0]      data_out,
    input  logic [1:0]                 err_num,
    // response channel
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DATA_WIDTH-1:0]      rsp_data,
    output logic [1:0]                 rsp_err_num,
    output logic                       rsp_timeout
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_WAIT_DONE,
        ST_RESP
    } state_t;

    localparam logic [1:0] OP_ILLEGAL = 2'b11;
    localparam logic [1:0] BEAT_CTRL  = 2'd3;

    state_t                 state_q, state_d;
    logic [1:0]             beat_q, beat_d;

    logic [1:0]             op_q, op_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic [1:0]             width_q, width_d;
    logic [DATA_WIDTH-1:0]  noise_q, noise_d;

    logic [DATA_WIDTH-1:0]  rsp_data_q, rsp_data_d;
    logic [1:0]             rsp_err_q, rsp_err_d;

    logic                   accept;
    logic                   wd_expired;

    assign accept = (state_q == ST_IDLE) && req_valid;

`ifdef ECC_SEQ_WATCHDOG_EN
    localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [WD_W-1:0]        wd_cnt_q, wd_cnt_d;
    logic                   rsp_timeout_q, rsp_timeout_d;

    // Last WAIT_DONE cycle before the limit is reached; counts 0..TIMEOUT_CYCLES-1.
    assign wd_expired = (state_q == ST_WAIT_DONE) && !operation_done &&
                        (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));

    // Watchdog counts only while waiting for the core and clears otherwise.
    always_comb begin
        wd_cnt_d = '0;
        if ((state_q == ST_WAIT_DONE) && !operation_done && !wd_expired) begin
            wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
    end

    // Watchdog and timeout flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_q      <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            wd_cnt_q      <= wd_cnt_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end
`else
    localparam int unsigned UNUSED_TIMEOUT_CYCLES = TIMEOUT_CYCLES;

    assign wd_expired = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    // Next-state logic: four SETUP/ACCESS beat pairs, then wait and respond.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    beat_d  = '0;
                    state_d = (req_op == OP_ILLEGAL) ? ST_RESP : ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                // beat index wraps back to 0 after the CTRL beat
                beat_d  = beat_q + 2'd1;
                state_d = (beat_q == BEAT_CTRL) ? ST_WAIT_DONE : ST_SETUP;
            end
            ST_WAIT_DONE: begin
                if (operation_done || wd_expired) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                beat_d  = '0;
            end
        endcase
    end

    // Command capture on accept; response capture on done, illegal op or timeout.
    always_comb begin
        op_d       = op_q;
        data_d     = data_q;
        width_d    = width_q;
        noise_d    = noise_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
`ifdef ECC_SEQ_WATCHDOG_EN
        rsp_timeout_d = rsp_timeout_q;
`endif
        if (accept) begin
            op_d    = req_op;
            data_d  = req_data;
            width_d = req_width;
            noise_d = req_noise;
            if (req_op == OP_ILLEGAL) begin
                rsp_data_d = '0;
                rsp_err_d  = 2'b11;
`ifdef ECC_SEQ_WATCHDOG_EN
                rsp_timeout_d = 1'b0;
`endif
            end
        end else if ((state_q == ST_WAIT_DONE) && operation_done) begin
            rsp_data_d = data_out;
            rsp_err_d  = err_num;
`ifdef ECC_SEQ_WATCHDOG_EN
            rsp_timeout_d = 1'b0;
`endif
        end else if (wd_expired) begin
            rsp_data_d = '0;
            rsp_err_d  = 2'b11;
`ifdef ECC_SEQ_WATCHDOG_EN
            rsp_timeout_d = 1'b1;
`endif
        end
    end

    // Command and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q       <= '0;
            data_q     <= '0;
            width_q    <= '0;
            noise_q    <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= '0;
        end else begin
            op_q       <= op_d;
            data_q     <= data_d;
            width_q    <= width_d;
            noise_q    <= noise_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    // Output decode: APB signals only in SETUP/ACCESS, response only in RESP.
    always_comb begin
        req_ready   = (state_q == ST_IDLE);
        PSEL        = 1'b0;
        PENABLE     = 1'b0;
        PWRITE      = 1'b0;
        PADDR       = '0;
        PWDATA      = '0;
        rsp_valid   = 1'b0;
        rsp_data    = '0;
        rsp_err_num = '0;
        rsp_timeout = 1'b0;
        if ((state_q == ST_SETUP) || (state_q == ST_ACCESS)) begin
            PSEL    = 1'b1;
            PENABLE = (state_q == ST_ACCESS);
            PWRITE  = 1'b1;
            unique case (beat_q)
                2'd0: begin
                    PADDR  = AMBA_ADDR_WIDTH'(8'h04);
                    PWDATA = AMBA_WORD'(data_q);
                end
                2'd1: begin
                    PADDR  = AMBA_ADDR_WIDTH'(8'h08);
                    PWDATA = AMBA_WORD'(width_q);
                end
                2'd2: begin
                    PADDR  = AMBA_ADDR_WIDTH'(8'h0C);
                    PWDATA = AMBA_WORD'(noise_q);
                end
                default: begin
                    PADDR  = AMBA_ADDR_WIDTH'(8'h00);
                    PWDATA = AMBA_WORD'(op_q);
                end
            endcase
        end
        if (state_q == ST_RESP) begin
            rsp_valid   = 1'b1;
            rsp_data    = rsp_data_q;
            rsp_err_num = rsp_err_q;
`ifdef ECC_SEQ_WATCHDOG_EN
            rsp_timeout = rsp_timeout_q;
`endif
        end
    end

endmodule

// File: tb/tb_ecc_apb_sequencer.sv
// Directed, table-driven bench for ecc_apb_sequencer plus hand-written
// sequences for backpressure, stale done, reset mid-transfer and watchdog.
module tb_ecc_apb_sequencer;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_data;
    logic [1:0]  req_width;
    logic [31:0] req_noise;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [19:0] PADDR;
    logic [31:0] PWDATA;
    logic        operation_done;
    logic [31:0] data_out;
    logic [1:0]  err_num;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_err_num;
    logic        rsp_timeout;

    ecc_apb_sequencer #(
        .AMBA_WORD       (32),
        .AMBA_ADDR_WIDTH (20),
        .DATA_WIDTH      (32),
        .TIMEOUT_CYCLES  (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_data       (req_data),
        .req_width      (req_width),
        .req_noise      (req_noise),
        .PSEL           (PSEL),
        .PENABLE        (PENABLE),
        .PWRITE         (PWRITE),
        .PADDR          (PADDR),
        .PWDATA         (PWDATA),
        .operation_done (operation_done),
        .data_out       (data_out),
        .err_num        (err_num),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .rsp_err_num    (rsp_err_num),
        .rsp_timeout    (rsp_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] data;
        logic [1:0]  width;
        logic [31:0] noise;
        logic [31:0] done_data;
        logic [1:0]  done_err;
        int          stall;
        bit          stale;
        logic [31:0] exp_data;
        logic [1:0]  exp_err;
    } vec_t;

    vec_t vecs[5];
    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    function automatic logic [19:0] exp_addr(input int b);
        case (b)
            0: return 20'h04;
            1: return 20'h08;
            2: return 20'h0C;
            default: return 20'h00;
        endcase
    endfunction

    function automatic logic [31:0] exp_wdata(input vec_t v, input int b);
        case (b)
            0: return v.data;
            1: return {30'b0, v.width};
            2: return v.noise;
            default: return {30'b0, v.op};
        endcase
    endfunction

    // Present a command at a negedge; it is accepted at the next posedge.
    task automatic send_cmd(input vec_t v);
        @(negedge clk);
        check("req_ready_idle", req_ready, 1'b1);
        req_valid = 1'b1;
        req_op    = v.op;
        req_data  = v.data;
        req_width = v.width;
        req_noise = v.noise;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_data  = 32'h0BAD_F00D;
        req_noise = 32'h0BAD_F00D;
    endtask

    // Check the four SETUP/ACCESS beat pairs, optionally pulsing a stale done in beat 1.
    task automatic apb_beats(input vec_t v);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            check($sformatf("setup_ctl_b%0d", b), {PSEL, PENABLE, PWRITE}, 3'b101);
            check($sformatf("setup_addr_b%0d", b), PADDR, exp_addr(b));
            check($sformatf("setup_wdata_b%0d", b), PWDATA, exp_wdata(v, b));
            if (v.stale && b == 1) begin
                operation_done = 1'b1;
                data_out       = 32'hBAD0_BAD0;
                err_num        = 2'b01;
            end
            @(negedge clk);
            operation_done = 1'b0;
            check($sformatf("access_ctl_b%0d", b), {PSEL, PENABLE, PWRITE}, 3'b111);
            check($sformatf("access_addr_b%0d", b), PADDR, exp_addr(b));
            check($sformatf("access_wdata_b%0d", b), PWDATA, exp_wdata(v, b));
            check("no_rsp_during_apb", rsp_valid, 1'b0);
        end
    endtask

    // Check the held response, stall rsp_ready, then complete the handshake.
    task automatic check_resp(input vec_t v, input logic exp_to);
        @(negedge clk);
        check("rsp_valid", rsp_valid, 1'b1);
        check("rsp_data", rsp_data, v.exp_data);
        check("rsp_err_num", rsp_err_num, v.exp_err);
        check("rsp_timeout", rsp_timeout, exp_to);
        check("resp_apb_idle", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, '0);
        check("req_ready_resp", req_ready, 1'b0);
        for (int s = 0; s < v.stall; s++) begin
            @(negedge clk);
            check("stall_valid", rsp_valid, 1'b1);
            check("stall_data", {rsp_data, rsp_err_num, rsp_timeout}, {v.exp_data, v.exp_err, exp_to});
            check("stall_req_ready", req_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        check("post_hs_valid", rsp_valid, 1'b0);
        check("post_hs_req_ready", req_ready, 1'b1);
    endtask

    // Wait a cycle in WAIT_DONE, then deliver operation_done with the core result.
    task automatic complete(input vec_t v);
        @(negedge clk);
        check("wait_apb_idle", {PSEL, PENABLE, PWRITE}, 3'b000);
        check("wait_no_rsp", rsp_valid, 1'b0);
        operation_done = 1'b1;
        data_out       = v.done_data;
        err_num        = v.done_err;
        @(posedge clk);
        #1;
        operation_done = 1'b0;
        data_out       = 32'h5A5A_5A5A;
        err_num        = 2'b10;
        check_resp(v, 1'b0);
    endtask

    task automatic run_vec(input vec_t v);
        send_cmd(v);
        if (v.op == 2'b11) begin
            check_resp(v, 1'b0);
        end else begin
            apb_beats(v);
            complete(v);
        end
    endtask

    initial begin
        int cyc;
        int seen;
        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_data = '0; req_width = '0;
        req_noise = '0; operation_done = 1'b0; data_out = '0; err_num = '0; rsp_ready = 1'b0;

        vecs[0] = '{op:2'b00, data:32'h0000_00A5, width:2'd0, noise:32'h0000_0010,
                    done_data:32'h0000_1234, done_err:2'd0, stall:0, stale:1'b0,
                    exp_data:32'h0000_1234, exp_err:2'd0};
        vecs[1] = '{op:2'b01, data:32'h0000_0F3C, width:2'd2, noise:32'h0000_0100,
                    done_data:32'h0000_0F3C, done_err:2'd1, stall:5, stale:1'b0,
                    exp_data:32'h0000_0F3C, exp_err:2'd1};
        vecs[2] = '{op:2'b10, data:32'hDEAD_BEEF, width:2'd1, noise:32'h8000_0001,
                    done_data:32'hCAFE_0001, done_err:2'd2, stall:0, stale:1'b1,
                    exp_data:32'hCAFE_0001, exp_err:2'd2};
        vecs[3] = '{op:2'b11, data:32'h0000_0055, width:2'd3, noise:32'h0000_00FF,
                    done_data:32'h1111_1111, done_err:2'd1, stall:1, stale:1'b0,
                    exp_data:32'h0000_0000, exp_err:2'd3};
        vecs[4] = '{op:2'b00, data:32'hFFFF_FFFF, width:2'd3, noise:32'hFFFF_FFFF,
                    done_data:32'hFFFF_FFFF, done_err:2'd3, stall:2, stale:1'b0,
                    exp_data:32'hFFFF_FFFF, exp_err:2'd3};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_req_ready", req_ready, 1'b1);
        check("reset_apb", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, '0);
        check("reset_rsp", {rsp_valid, rsp_data, rsp_err_num, rsp_timeout}, '0);

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Reset during the ACCESS phase of beat 2 aborts the transfer.
        send_cmd(vecs[2]);
        repeat (6) @(negedge clk);
        check("pre_rst_access_b2", {PSEL, PENABLE, PADDR}, {2'b11, 20'h0C});
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_abort_apb", {PSEL, PENABLE}, 2'b00);
        check("rst_abort_req_ready", req_ready, 1'b1);
        check("rst_abort_rsp", rsp_valid, 1'b0);
        run_vec(vecs[1]);

        // No operation_done: watchdog timeout if enabled, otherwise wait forever.
        send_cmd(vecs[0]);
        apb_beats(vecs[0]);
`ifdef ECC_SEQ_WATCHDOG_EN
        cyc = 0;
        @(negedge clk);
        while (rsp_valid !== 1'b1 && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        check("wd_wait_cycles", cyc, 16);
        check("wd_rsp", {rsp_valid, rsp_data, rsp_err_num, rsp_timeout}, {1'b1, 32'h0, 2'b11, 1'b1});
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check("wd_post_hs_req_ready", req_ready, 1'b1);
        seen = 0;
`else
        seen = 0;
        cyc  = 0;
        repeat (1000) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) seen++;
        end
        check("no_wd_no_rsp", seen, 0);
        complete(vecs[0]);
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
